// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions used by the iterative multiply/divide unit.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h80000000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  // rs1 is treated as signed for MUL (low word is sign-agnostic), MULH, MULHSU, DIV and REM.
  function automatic logic opASigned(input md_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic opBSigned(input md_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/exec_muldiv_md_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring-divide step on magnitudes.
module md_step
  import riscv_pkg::*;
(
  input  logic            i_isDiv,
  input  logic [XLEN:0]   i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN:0]   o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_addSum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic [XLEN:0] w_rem;
  logic          w_ge;

  // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    w_addSum  = i_hi + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shifted = {i_hi[XLEN-1:0], i_lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, i_b};
    w_ge      = (w_shifted >= {1'b0, i_b});
    w_rem     = w_ge ? w_diff : w_shifted;
    o_hi      = '0;
    o_lo      = '0;
    if (i_isDiv) begin
      o_hi = w_rem;
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = {1'b0, w_addSum[XLEN:1]};
      o_lo = {w_addSum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 iterations per op, single-cycle fast path for
// divide-by-zero and signed overflow, one-cycle done strobe with registered result.
module exec_muldiv
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            starte,
  input  logic [2:0]      mdOpe,
  input  logic [XLEN-1:0] rd1e,
  input  logic [XLEN-1:0] rd2e,
  input  logic [4:0]      rde,
  input  logic            kill,
  output logic            busye,
  output logic            donee,
  output logic [XLEN-1:0] resulte,
  output logic [4:0]      rdOute
);

  md_state_t       r_state;
  md_state_t       w_nextState;
  md_op_t          r_op;
  logic [4:0]      r_count;
  logic [4:0]      r_rd;
  logic            r_neg;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;

  md_op_t          w_op;
  logic            w_start;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;
  logic            w_neg;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_fast;
  logic [XLEN-1:0] w_fastResult;

  logic [XLEN:0]     w_stepHi;
  logic [XLEN-1:0]   w_stepLo;
  logic [2*XLEN-1:0] w_product;
  logic [2*XLEN-1:0] w_prodSigned;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_finalResult;

  assign w_op    = md_op_t'(mdOpe);
  assign w_start = (r_state == IDLE) && starte && !kill;

  // Operand conditioning at capture time: magnitudes, result sign and special-case detection.
  always_comb begin
    w_aNeg     = opASigned(w_op) && rd1e[XLEN-1];
    w_bNeg     = opBSigned(w_op) && rd2e[XLEN-1];
    w_aMag     = w_aNeg ? -rd1e : rd1e;
    w_bMag     = w_bNeg ? -rd2e : rd2e;
    w_neg      = (w_op == MD_REM) ? w_aNeg : (w_aNeg ^ w_bNeg);
    w_divZero  = w_op[2] && (rd2e == '0);
    w_overflow = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                 (rd1e == INT_MIN) && (rd2e == '1);
    w_fast     = w_divZero || w_overflow;
    w_fastResult = '0;
    if (w_divZero) begin
      w_fastResult = w_op[1] ? rd1e : DIV_ZERO_Q;
    end else if (w_overflow) begin
      w_fastResult = w_op[1] ? '0 : INT_MIN;
    end
  end

  md_step u_step (
    .i_isDiv (r_op[2]),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .i_b     (r_b),
    .o_hi    (w_stepHi),
    .o_lo    (w_stepLo)
  );

  // The result is formed from the last iteration's outputs so it can be registered entering DONE.
  always_comb begin
    w_product     = {w_stepHi[XLEN-1:0], w_stepLo};
    w_prodSigned  = r_neg ? -w_product : w_product;
    w_quot        = r_neg ? -w_stepLo : w_stepLo;
    w_rem         = r_neg ? -w_stepHi[XLEN-1:0] : w_stepHi[XLEN-1:0];
    w_finalResult = '0;
    case (r_op)
      MD_MUL:                          w_finalResult = w_prodSigned[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:    w_finalResult = w_prodSigned[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:                 w_finalResult = w_quot;
      MD_REM, MD_REMU:                 w_finalResult = w_rem;
      default:                         w_finalResult = '0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (starte) w_nextState = w_fast ? DONE : BUSY;
      BUSY:    if (r_count == 5'd31) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (kill) w_nextState = IDLE;
  end

  assign busye = !clr && (w_start || (r_state == BUSY));
  assign donee = !clr && !kill && (r_state == DONE);

  // resulte/rdOute only change when an op completes, so they hold across idle periods.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_op    <= MD_MUL;
      r_count <= '0;
      r_rd    <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      resulte <= '0;
      rdOute  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_start) begin
        r_op    <= w_op;
        r_rd    <= rde;
        r_neg   <= w_neg;
        r_hi    <= '0;
        r_lo    <= w_aMag;
        r_b     <= w_bMag;
        r_count <= '0;
        if (w_fast) begin
          resulte <= w_fastResult;
          rdOute  <= rde;
        end
      end else if ((r_state == BUSY) && !kill) begin
        r_hi    <= w_stepHi;
        r_lo    <= w_stepLo;
        r_count <= r_count + 5'd1;
        if (r_count == 5'd31) begin
          resulte <= w_finalResult;
          rdOute  <= r_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: scoreboard of expected results, cycle-exact busye/donee checks.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        clr;
  logic        starte;
  logic [2:0]  mdOpe;
  logic [31:0] rd1e;
  logic [31:0] rd2e;
  logic [4:0]  rde;
  logic        kill;
  logic        busye;
  logic        donee;
  logic [31:0] resulte;
  logic [4:0]  rdOute;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  exec_muldiv dut (
    .clk     (clk),
    .clr     (clr),
    .starte  (starte),
    .mdOpe   (mdOpe),
    .rd1e    (rd1e),
    .rd2e    (rd2e),
    .rde     (rde),
    .kill    (kill),
    .busye   (busye),
    .donee   (donee),
    .resulte (resulte),
    .rdOute  (rdOute)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          sa;
    longint          sb2;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa  = $signed(a);
    sb2 = $signed(b);
    ua  = a;
    ub  = b;
    p   = '0;
    case (op)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ua;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb2; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb2; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 32'h0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resulte", 64'(resulte), 64'(e.result));
      check("rdOute", 64'(rdOute), 64'(e.rd));
    end
  endtask

  // Issues one op in cycle 0, scrambles operands while busy, and checks busye/donee every cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    exp_t e;
    int   lat;
    lat      = expLatency(op, a, b);
    e.result = modelResult(op, a, b);
    e.rd     = rd;
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        starte = 1'b1; mdOpe = op; rd1e = a; rd2e = b; rde = rd;
      end else begin
        rd1e = $urandom; rd2e = $urandom; rde = 5'($urandom);
      end
      #1;
      check($sformatf("busye@%0d", k), 64'(busye), 64'(k < lat));
      check($sformatf("donee@%0d", k), 64'(donee), 64'(k == lat));
      if (k == lat) checkOutput();
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    starte = 1'b0;
    #1;
    check("idleBusy", 64'(busye), 64'(0));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    clr = 1'b1; starte = 1'b1; kill = 1'b0; mdOpe = '0; rd1e = '0; rd2e = '0; rde = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rstBusy", 64'(busye), 64'(0));
    check("rstDone", 64'(donee), 64'(0));
    check("rstResult", 64'(resulte), 64'(0));
    check("rstRd", 64'(rdOute), 64'(0));
    @(negedge clk);
    clr = 1'b0; starte = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1);
    idleCycle();
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    idleCycle();
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    idleCycle();
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
    idleCycle();
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5);
    idleCycle();
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
    idleCycle();
    applyStimulus(3'd5, 32'hFFFFFFF9, 32'd2, 5'd7);
    idleCycle();
    applyStimulus(3'd7, 32'hFFFFFFF9, 32'd2, 5'd8);
    idleCycle();

    applyStimulus(3'd5, 32'd5, 32'd0, 5'd9);
    idleCycle();
    applyStimulus(3'd6, 32'd5, 32'd0, 5'd10);
    idleCycle();
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11);
    idleCycle();
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    idleCycle();

    // Kill in BUSY cycle 10: the op must vanish without a done strobe.
    @(negedge clk);
    starte = 1'b1; mdOpe = 3'd0; rd1e = 32'd9; rd2e = 32'd9; rde = 5'd13;
    repeat (9) @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    check("killBusyNow", 64'(busye), 64'(1));
    @(negedge clk);
    kill = 1'b0; starte = 1'b0;
    #1;
    check("killBusyNext", 64'(busye), 64'(0));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      check("killNoDone", 64'(donee), 64'(0));
    end
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd14);
    idleCycle();

    // Back-to-back: starte stays high through DONE into the next op.
    applyStimulus(3'd0, 32'd100, 32'hFFFFFFF6, 5'd15);
    applyStimulus(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd16);
    idleCycle();

    for (int n = 0; n < 6; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = (n == 5) ? 32'hFFFFFFF9 : $urandom_range(1, 1000);
      applyStimulus(rop, ra, rb, 5'($urandom));
      idleCycle();
    end

    // Synchronous clear mid-BUSY returns every output to its reset value.
    @(negedge clk);
    starte = 1'b1; mdOpe = 3'd0; rd1e = 32'd5; rd2e = 32'd6; rde = 5'd20;
    repeat (5) @(negedge clk);
    clr = 1'b1; starte = 1'b0;
    @(negedge clk);
    #1;
    check("clrBusy", 64'(busye), 64'(0));
    check("clrDone", 64'(donee), 64'(0));
    check("clrResult", 64'(resulte), 64'(0));
    check("clrRd", 64'(rdOute), 64'(0));
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check("clrNoDone", 64'(donee), 64'(0));
    end
    check("sbEmpty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
